// File: rtl/uart_pkg.sv
// Shared types and helpers for the adaptive-UART transmit path.
package uart_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int RR_MAX     = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} tx_sched_state_t;

  // Rotating-priority pick: first set bit at or above ptr, wrapping at n (n <= RR_MAX).
  function automatic logic [2:0] rr_pick(input logic [RR_MAX-1:0] valid,
                                         input logic [2:0] ptr, input int n);
    logic [2:0] win;
    logic       found;
    int         idx;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < RR_MAX; k++) begin
      idx = (int'(ptr) + k) % n;
      if (k < n && !found && valid[idx[2:0]]) begin
        win   = idx[2:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational rotating-priority picker: request vector plus pointer in,
// one-hot grant and winner index out.
module uart_rr_arbiter
  import uart_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            hit
);

  logic [RR_MAX-1:0] req_ext;
  logic [2:0]        pick;

  always_comb begin
    req_ext            = '0;
    req_ext[NREQ-1:0]  = req;
    pick               = rr_pick(req_ext, 3'(ptr), NREQ);
    idx                = pick[IW-1:0];
    hit                = |req;
    gnt                = hit ? (NREQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler feeding one UART serializer: one frame in flight,
// inter-frame idle gap, and repeat flagging of back-to-back identical bytes.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int GAP_CYC = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     idle_mode,
  output logic                     tx_valid,
  output logic [DATA_W-1:0]        tx_data,
  output logic                     tx_rep,
  input  logic                     tx_ready,
  input  logic                     tx_done,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy
);

  localparam int IW = $clog2(NREQ);
  localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

  tx_sched_state_t   state;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     win_idx;
  logic [NREQ-1:0]   win_gnt;
  logic              win_hit;
  logic [DATA_W-1:0] win_byte;
  logic [DATA_W-1:0] last_byte;
  logic              last_valid;
  logic [GW-1:0]     gap_cnt;

  uart_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (win_gnt),
    .idx (win_idx),
    .hit (win_hit)
  );

  assign win_byte = req_data[win_idx*DATA_W +: DATA_W];

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
  // producers hold valid/data until then, and req_ready is only offered in IDLE.
  assign req_ready = (rst_n && state == IDLE) ? win_gnt : '0;
  assign tx_valid  = (state == ISSUE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx_data    <= '0;
      tx_rep     <= 1'b0;
      grant_id   <= '0;
      rr_ptr     <= '0;
      last_byte  <= '0;
      last_valid <= 1'b0;
      gap_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_hit) begin
            tx_data  <= win_byte;
            grant_id <= win_idx;
            tx_rep   <= idle_mode && last_valid && (win_byte == last_byte);
            rr_ptr   <= (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          // tx_done cannot belong to this frame yet, so it is ignored here.
          if (tx_ready) begin
            last_byte  <= tx_data;
            last_valid <= 1'b1;
            state      <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (tx_done) begin
            if (GAP_CYC == 0) begin
              state <= IDLE;
            end else begin
              gap_cnt <= GW'(GAP_CYC);
              state   <= GAP;
            end
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - 1'b1;
          if (gap_cnt == GW'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: directed frames, a requester model,
// and a monitor that checks every serializer handshake against exp_q.
module tb_uart_tx_sched;

  localparam int NREQ = 4;
  localparam int DW   = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // main instance (GAP_CYC = 2)
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               idle_mode, tx_valid, tx_rep, tx_ready, tx_done, busy;
  logic [DW-1:0]      tx_data;
  logic [1:0]         grant_id;

  // zero-gap instance
  logic [NREQ-1:0]    z_req_valid;
  logic [NREQ*DW-1:0] z_req_data;
  logic [NREQ-1:0]    z_req_ready;
  logic               z_idle_mode, z_tx_valid, z_tx_rep, z_tx_ready, z_tx_done, z_busy;
  logic [DW-1:0]      z_tx_data;
  logic [1:0]         z_grant_id;

  uart_tx_sched #(.NREQ(NREQ), .DATA_W(DW), .GAP_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .idle_mode(idle_mode), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_rep(tx_rep), .tx_ready(tx_ready), .tx_done(tx_done),
    .grant_id(grant_id), .busy(busy)
  );

  uart_tx_sched #(.NREQ(NREQ), .DATA_W(DW), .GAP_CYC(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(z_req_valid), .req_data(z_req_data),
    .req_ready(z_req_ready), .idle_mode(z_idle_mode), .tx_valid(z_tx_valid),
    .tx_data(z_tx_data), .tx_rep(z_tx_rep), .tx_ready(z_tx_ready), .tx_done(z_tx_done),
    .grant_id(z_grant_id), .busy(z_busy)
  );

  // scoreboard state
  int          tests = 0;
  int          fails = 0;
  logic [10:0] exp_q[$];
  logic [10:0] mon_exp;
  logic [7:0]  src_q[NREQ][$];
  int          acc_cnt[NREQ];
  logic        took[NREQ];

  function automatic logic [10:0] mk(input logic [1:0] gid, input logic [7:0] d, input logic r);
    return {gid, d, r};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // requester model: presents the head of each src_q until accepted
  initial begin
    req_valid = '0;
    req_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      took[i]    = 1'b0;
      acc_cnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (took[i] && src_q[i].size() > 0) begin
          void'(src_q[i].pop_front());
          acc_cnt[i]++;
        end
        took[i]              = 1'b0;
        req_valid[i]         = (src_q[i].size() > 0);
        req_data[i*DW +: DW] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
      end
      #1;
      for (int i = 0; i < NREQ; i++) took[i] = rst_n && req_valid[i] && req_ready[i];
    end
  end

  // monitor: every serializer handshake pops one expected frame
  always begin
    @(negedge clk);
    #2;
    if (rst_n && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL frame_unexpected: got gid=%0d data=0x%0h rep=%0b, expected none",
                 grant_id, tx_data, tx_rep);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("frame{gid,data,rep}", {21'd0, grant_id, tx_data, tx_rep}, {21'd0, mon_exp});
      end
    end
    if (rst_n && req_ready != '0)
      chk("req_ready_onehot_valid", {30'd0, $onehot(req_ready), (req_ready & ~req_valid) == '0},
          32'd3);
  end

  task automatic wait_hs(output bit ok);
    int n;
    n = 0;
    while (!(tx_valid && tx_ready) && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    ok = tx_valid && tx_ready;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL hs_timeout: got no tx handshake, expected one within 200 cycles");
    end
  endtask

  // serializer driver: accept the frame, pulse tx_done, wait out the gap
  task automatic serve(input bit chk_gap);
    bit ok;
    int n;
    wait_hs(ok);
    if (!ok) return;
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    #1;
    if (chk_gap) begin
      chk("gap_busy_cyc1", busy, 1);
      @(negedge clk); #1;
      chk("gap_busy_cyc2", busy, 1);
      @(negedge clk); #1;
      chk("gap_exit_idle", busy, 0);
    end else begin
      n = 0;
      while (busy && n < 50) begin
        @(negedge clk); #1;
        n++;
      end
      chk("frame_end_idle", busy, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200us");
    $fatal(1);
  end

  initial begin
    bit ok;
    int n;
    rst_n = 1'b0; idle_mode = 1'b0; tx_ready = 1'b0; tx_done = 1'b0;
    z_req_valid = '0; z_req_data = '0; z_idle_mode = 1'b0; z_tx_ready = 1'b0; z_tx_done = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_rep", tx_rep, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // single byte, gap timing
    tx_ready = 1'b1;
    exp_q.push_back(mk(2'd0, 8'hA5, 1'b0));
    src_q[0].push_back(8'hA5);
    serve(1'b1);
    chk("single_accept_once", acc_cnt[0], 1);

    // repeat detection from requester 1 (last byte on the wire is A5)
    idle_mode = 1'b1;
    exp_q.push_back(mk(2'd1, 8'hA5, 1'b1)); src_q[1].push_back(8'hA5); serve(1'b0);
    exp_q.push_back(mk(2'd1, 8'hA5, 1'b1)); src_q[1].push_back(8'hA5); serve(1'b0);
    idle_mode = 1'b0;
    exp_q.push_back(mk(2'd1, 8'h3C, 1'b0)); src_q[1].push_back(8'h3C); serve(1'b0);
    idle_mode = 1'b1;
    exp_q.push_back(mk(2'd1, 8'h3C, 1'b1)); src_q[1].push_back(8'h3C); serve(1'b0);

    // backpressure with spurious tx_done; requester 1 waits behind requester 2
    idle_mode = 1'b0;
    tx_ready  = 1'b0;
    exp_q.push_back(mk(2'd2, 8'h5A, 1'b0));
    exp_q.push_back(mk(2'd1, 8'h77, 1'b0));
    src_q[2].push_back(8'h5A);
    src_q[1].push_back(8'h77);
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!tx_valid && n < 100);
    chk("bp_issue_seen", tx_valid, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tx_done = (k == 2);
      #1;
      chk("bp_tx_valid_held", tx_valid, 1);
      chk("bp_tx_data_stable", tx_data, 32'h5A);
      chk("bp_no_req_ready", req_ready, 0);
    end
    tx_ready = 1'b1;
    serve(1'b0);

    // reset while waiting for tx_done
    wait_hs(ok);
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_valid", tx_valid, 0);
    chk("mid_rst_tx_data", tx_data, 0);
    chk("mid_rst_grant_id", grant_id, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_mode = 1'b1;
    exp_q.push_back(mk(2'd3, 8'hA5, 1'b0));
    src_q[3].push_back(8'hA5);
    serve(1'b0);

    // round robin, all four pending, pointer starts at 0
    idle_mode = 1'b0;
    exp_q.push_back(mk(2'd0, 8'h10, 1'b0));
    exp_q.push_back(mk(2'd1, 8'h11, 1'b0));
    exp_q.push_back(mk(2'd2, 8'h12, 1'b0));
    exp_q.push_back(mk(2'd3, 8'h13, 1'b0));
    exp_q.push_back(mk(2'd0, 8'h10, 1'b0));
    src_q[0].push_back(8'h10); src_q[1].push_back(8'h11);
    src_q[2].push_back(8'h12); src_q[3].push_back(8'h13);
    src_q[0].push_back(8'h10);
    for (int f = 0; f < 5; f++) serve(1'b0);

    // zero-gap instance: next grant the cycle after tx_done
    @(negedge clk);
    z_req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    z_req_valid = 4'b0011;
    z_tx_ready  = 1'b1;
    #1;
    chk("gap0_first_ready", z_req_ready, 32'h1);
    @(negedge clk);
    z_req_valid = 4'b0010;
    #1;
    chk("gap0_tx_valid", z_tx_valid, 1);
    chk("gap0_tx_data0", z_tx_data, 32'h10);
    @(negedge clk);
    z_tx_done = 1'b1;
    #1;
    chk("gap0_wait_busy", z_busy, 1);
    chk("gap0_wait_no_ready", z_req_ready, 0);
    @(negedge clk);
    z_tx_done = 1'b0;
    #1;
    chk("gap0_next_ready", z_req_ready, 32'h2);
    @(negedge clk);
    z_req_valid = 4'b0000;
    #1;
    chk("gap0_tx_data1", z_tx_data, 32'h11);
    chk("gap0_grant1", z_grant_id, 1);
    @(negedge clk); z_tx_done = 1'b1;
    @(negedge clk); z_tx_done = 1'b0;

    repeat (3) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Round-robin scheduler that shares the single UART serializer in the adaptive-UART design among several byte producers. It accepts bytes over per-requester valid/ready handshakes and issues exactly one frame at a time to the serializer. It waits for frame completion and enforces a configurable inter-frame idle gap. When idle_mode is set, it flags back-to-back identical bytes as repeats (REP_FLAG) so the serializer can send its compressed repeat form.

Parameters:
NREQ, 4, number of requesters (2..8)
DATA_W, 8, byte width
GAP_CYC, 2, idle clock cycles inserted after each frame's tx_done (0 allowed = no gap)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  requester i has a byte pending
req_data  input  NREQ*DATA_W  byte of requester i at bits [i*DATA_W +: DATA_W]
req_ready  output  NREQ  one-hot acceptance pulse; byte taken when valid&ready
idle_mode  input  1  enables repeat detection (sampled at grant)
tx_valid  output  1  frame request to serializer
tx_data  output  DATA_W  byte to serialize
tx_rep  output  1  REP_FLAG: byte equals previous transmitted byte
tx_ready  input  1  serializer accepts frame when tx_valid&tx_ready
tx_done  input  1  one-cycle pulse, serializer finished current frame
grant_id  output  $clog2(NREQ)  index of requester owning current frame
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; req_ready=0, tx_valid=0, tx_data=0, tx_rep=0, grant_id=0, busy=0; rr pointer=0; last_valid=0, last_byte=0. All of these take effect immediately, including mid-frame; the serializer is reset by the same rst_n.
- FSM states: IDLE, ISSUE, WAIT_DONE, GAP.
- IDLE:
  - If any req_valid, pick the first set bit scanning from rr pointer upward with wrap.
  - Same cycle: drive req_ready one-hot for the winner (combinational from state+req_valid).
  - Next edge: latch tx_data=winner byte and grant_id=winner.
  - Next edge: latch tx_rep = idle_mode & last_valid & (byte==last_byte).
  - Next edge: rr pointer = winner+1 mod NREQ; go ISSUE.
  - No req_valid: stay in IDLE; req_ready=0.
- ISSUE:
  - tx_valid=1; tx_data, tx_rep, grant_id stable.
  - On tx_valid&tx_ready: last_byte=tx_data, last_valid=1, go WAIT_DONE.
  - tx_done in ISSUE is ignored.
- WAIT_DONE:
  - tx_valid=0.
  - On tx_done: go GAP and load gap counter with GAP_CYC.
  - If GAP_CYC=0: go directly to IDLE.
- GAP:
  - Counter decrements each cycle; go IDLE when it reaches 1→0, i.e. exactly GAP_CYC cycles spent in GAP.
- Throughput: grant→tx_valid latency is 1 cycle. A new grant is possible the cycle after the GAP exit.
- req_ready is asserted only in IDLE, at most one bit, and only to a requester with valid=1.
- Requesters must hold valid/data stable until accepted. Withdrawn valid before grant is legal.
- Repeat detection:
  - Compares against the last byte actually handed to the serializer, regardless of requester.
  - idle_mode=0 forces tx_rep=0 but still updates last_byte.
- Fairness: a requester continuously asserting valid waits at most NREQ-1 frames.

Decomposition:
- Shared package uart_pkg holds:
  - state enum tx_sched_state_t {IDLE, ISSUE, WAIT_DONE, GAP};
  - default DATA_W constant;
  - a function rr_pick(valid, ptr) returning the winner index.
- One sub-module is natural: uart_rr_arbiter (NREQ-wide rotating priority picker: req vector + pointer in, one-hot grant + index out, purely combinational).
- FSM, latches and gap counter stay in uart_tx_sched.

Test Plan:
- Single byte: req_valid=4'b0001, data0=0xA5, idle_mode=0, tx_ready=1 -> req_ready[0] one pulse, tx_valid next cycle with tx_data=0xA5, tx_rep=0, grant_id=0; after tx_done, busy stays high 2 cycles then drops.
- Repeat: send 0xA5 then 0xA5 from requester 1 with idle_mode=1 -> second frame tx_rep=1. Then 0x3C with idle_mode=0 -> tx_rep=0. Then 0x3C with idle_mode=1 -> tx_rep=1.
- Round robin: all four valid continuously (0x10,0x11,0x12,0x13) -> grant_id sequence 0,1,2,3,0 and tx_data 0x10,0x11,0x12,0x13,0x10. rr wraps 3→0.
- Backpressure: tx_ready=0 for 5 cycles in ISSUE -> tx_valid held, tx_data stable, no new req_ready. A spurious tx_done during ISSUE is ignored.
- Reset mid-frame: assert rst_n=0 in WAIT_DONE -> all outputs 0 immediately, busy=0. After release, resend last byte 0xA5 with idle_mode=1 -> tx_rep=0 (last_valid cleared).
- GAP_CYC=0 instance: back-to-back requests -> next req_ready in the cycle following tx_done.
